// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
// Real-time clock and calendar with one alarm and a six-digit 7-segment view.
// A prescaler divides clk down to a one-second tick. The tick advances
// seconds, minutes, hours, day, month and year (2000..2099) through a
// same-cycle carry chain. Single-cycle set pulses adjust individual fields.
//
// Ports
//   clk                        system clock, rising edge
//   rst                        synchronous active-high reset
//   set_s                      clear seconds and prescaler
//   set_min/set_h/set_d/       increment one field, wrapping within that field
//   set_mon/set_y
//   set_amin/set_ah            increment alarm minute / alarm hour
//   alarm_en                   alarm enable level
//   mode[1:0]                  0 time, 1 date, 2 alarm, 3 auto-cycle time/date
//   segment[41:0]              left/middle/right digit pairs, a..g, active-low
//   alarm                      alarm indication
//   sec_tick                   one-cycle pulse per second
module rtc_calendar_core #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int CYCLE_S = 5,
  parameter int ALARM_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_s,
  input  logic        set_min,
  input  logic        set_h,
  input  logic        set_d,
  input  logic        set_mon,
  input  logic        set_y,
  input  logic        set_amin,
  input  logic        set_ah,
  input  logic        alarm_en,
  input  logic [1:0]  mode,
  output logic [41:0] segment,
  output logic        alarm,
  output logic        sec_tick
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0]    CYCLE_LAST = 6'(CYCLE_S - 1);
  localparam logic [5:0]    ALARM_LAST = 6'(ALARM_S - 1);
  localparam logic [13:0]   PAIR_BLANK = 14'h3FFF;

  // Active-low a..g pattern for one decimal digit; anything else is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h01;
      4'd1:    p = 7'h4F;
      4'd2:    p = 7'h12;
      4'd3:    p = 7'h06;
      4'd4:    p = 7'h4C;
      4'd5:    p = 7'h24;
      4'd6:    p = 7'h20;
      4'd7:    p = 7'h0F;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h04;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Two-digit decimal display of a 0..99 value: tens in the upper digit.
  function automatic logic [13:0] seg_pair(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {seg7(tens), seg7(units)};
  endfunction

  // Month length; the year field is 0..99, so divisible-by-4 is the low two bits.
  function automatic logic [4:0] days_in_month(input logic [3:0] mon, input logic [6:0] yr);
    logic [4:0] d;
    case (mon)
      4'd2:                      d = (yr[1:0] == 2'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
      default:                   d = 5'd31;
    endcase
    return d;
  endfunction

  logic [PW-1:0] presc_r, presc_n_s;
  logic [5:0]    sec_r, sec_n_s;
  logic [5:0]    min_r, min_n_s;
  logic [4:0]    hour_r, hour_n_s;
  logic [4:0]    day_r, day_n_s;
  logic [3:0]    mon_r, mon_n_s;
  logic [6:0]    year_r, year_n_s;
  logic [5:0]    amin_r, amin_n_s;
  logic [4:0]    ahour_r, ahour_n_s;
  logic [5:0]    cyc_r;
  logic          show_date_r;
  logic          alarm_r;
  logic [5:0]    alarm_left_r;
  logic          sec_tick_r;
  logic [41:0]   segment_r;

  logic          tick_s;
  logic [4:0]    dim_s;
  logic          carry_s_s, carry_m_s, carry_h_s, carry_d_s, carry_mo_s;
  logic          alarm_hit_s;
  logic [41:0]   time_view_s, date_view_s, alarm_view_s, seg_view_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign dim_s  = days_in_month(mon_r, year_r);

  // Next-state of the time/calendar/alarm fields; a set pulse on a field
  // swallows any carry arriving into it, so the chain stops there.
  always_comb begin
    presc_n_s  = presc_r;
    sec_n_s    = sec_r;
    min_n_s    = min_r;
    hour_n_s   = hour_r;
    day_n_s    = day_r;
    mon_n_s    = mon_r;
    year_n_s   = year_r;
    amin_n_s   = amin_r;
    ahour_n_s  = ahour_r;
    carry_s_s  = 1'b0;
    carry_m_s  = 1'b0;
    carry_h_s  = 1'b0;
    carry_d_s  = 1'b0;
    carry_mo_s = 1'b0;

    if (set_s || tick_s) begin
      presc_n_s = '0;
    end else begin
      presc_n_s = presc_r + PW'(1);
    end

    if (set_s) begin
      sec_n_s = 6'd0;
    end else if (tick_s) begin
      sec_n_s = (sec_r == 6'd59) ? 6'd0 : sec_r + 6'd1;
    end else begin
      sec_n_s = sec_r;
    end
    carry_s_s = tick_s && !set_s && (sec_r == 6'd59);

    if (set_min || carry_s_s) begin
      min_n_s = (min_r == 6'd59) ? 6'd0 : min_r + 6'd1;
    end else begin
      min_n_s = min_r;
    end
    carry_m_s = carry_s_s && !set_min && (min_r == 6'd59);

    if (set_h || carry_m_s) begin
      hour_n_s = (hour_r == 5'd23) ? 5'd0 : hour_r + 5'd1;
    end else begin
      hour_n_s = hour_r;
    end
    carry_h_s = carry_m_s && !set_h && (hour_r == 5'd23);

    // A day left past the month end by a month/year change is pulled back
    // one cycle later; an increment from an out-of-range day wraps to 1.
    if (set_d || carry_h_s) begin
      day_n_s = (day_r >= dim_s) ? 5'd1 : day_r + 5'd1;
    end else if (day_r > dim_s) begin
      day_n_s = dim_s;
    end else begin
      day_n_s = day_r;
    end
    carry_d_s = carry_h_s && !set_d && (day_r >= dim_s);

    if (set_mon || carry_d_s) begin
      mon_n_s = (mon_r == 4'd12) ? 4'd1 : mon_r + 4'd1;
    end else begin
      mon_n_s = mon_r;
    end
    carry_mo_s = carry_d_s && !set_mon && (mon_r == 4'd12);

    if (set_y || carry_mo_s) begin
      year_n_s = (year_r == 7'd99) ? 7'd0 : year_r + 7'd1;
    end else begin
      year_n_s = year_r;
    end

    if (set_amin) begin
      amin_n_s = (amin_r == 6'd59) ? 6'd0 : amin_r + 6'd1;
    end else begin
      amin_n_s = amin_r;
    end

    if (set_ah) begin
      ahour_n_s = (ahour_r == 5'd23) ? 5'd0 : ahour_r + 5'd1;
    end else begin
      ahour_n_s = ahour_r;
    end
  end

  assign alarm_hit_s = tick_s && alarm_en && (hour_n_s == ahour_n_s) &&
                       (min_n_s == amin_n_s) && (sec_n_s == 6'd0);

  assign time_view_s  = {seg_pair({2'b00, hour_r}), seg_pair({1'b0, min_r}), seg_pair({1'b0, sec_r})};
  assign date_view_s  = {seg_pair({2'b00, day_r}), seg_pair({3'b000, mon_r}), seg_pair(year_r)};
  assign alarm_view_s = {seg_pair({2'b00, ahour_r}), seg_pair({1'b0, amin_r}), PAIR_BLANK};

  // Select the view to be registered onto segment.
  always_comb begin
    seg_view_s = time_view_s;
    case (mode)
      2'd0: seg_view_s = time_view_s;
      2'd1: seg_view_s = date_view_s;
      2'd2: seg_view_s = alarm_view_s;
      2'd3: begin
        if (show_date_r) begin
          seg_view_s = date_view_s;
        end else begin
          seg_view_s = time_view_s;
        end
      end
      default: seg_view_s = time_view_s;
    endcase
  end

  // State registers: counters, alarm hold timer, auto-cycle view and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r      <= '0;
      sec_r        <= 6'd0;
      min_r        <= 6'd0;
      hour_r       <= 5'd0;
      day_r        <= 5'd1;
      mon_r        <= 4'd1;
      year_r       <= 7'd0;
      amin_r       <= 6'd0;
      ahour_r      <= 5'd0;
      cyc_r        <= 6'd0;
      show_date_r  <= 1'b0;
      alarm_r      <= 1'b0;
      alarm_left_r <= 6'd0;
      sec_tick_r   <= 1'b0;
      segment_r    <= {3{seg_pair(7'd0)}};
    end else begin
      presc_r    <= presc_n_s;
      sec_r      <= sec_n_s;
      min_r      <= min_n_s;
      hour_r     <= hour_n_s;
      day_r      <= day_n_s;
      mon_r      <= mon_n_s;
      year_r     <= year_n_s;
      amin_r     <= amin_n_s;
      ahour_r    <= ahour_n_s;
      sec_tick_r <= (presc_n_s == PRESC_LAST);
      segment_r  <= seg_view_s;

      // Alarm holds for ALARM_S ticks counted from the matching tick.
      if (!alarm_en) begin
        alarm_r      <= 1'b0;
        alarm_left_r <= 6'd0;
      end else if (alarm_hit_s) begin
        alarm_r      <= 1'b1;
        alarm_left_r <= ALARM_LAST;
      end else if (tick_s && alarm_r) begin
        if (alarm_left_r == 6'd0) begin
          alarm_r <= 1'b0;
        end else begin
          alarm_left_r <= alarm_left_r - 6'd1;
        end
      end

      // Auto-cycle view sits at time/count 0 whenever mode is not 3.
      if (mode != 2'd3) begin
        cyc_r       <= 6'd0;
        show_date_r <= 1'b0;
      end else if (tick_s) begin
        if (cyc_r == CYCLE_LAST) begin
          cyc_r       <= 6'd0;
          show_date_r <= !show_date_r;
        end else begin
          cyc_r <= cyc_r + 6'd1;
        end
      end
    end
  end

  assign segment  = segment_r;
  assign sec_tick = sec_tick_r;
  // Gated by the enable so that dropping alarm_en silences it immediately.
  assign alarm    = alarm_r && alarm_en;

endmodule

// File: tb/tb_rtc_calendar_core.sv
module tb_rtc_calendar_core;
  localparam int CLK_HZ  = 4;
  localparam int CYCLE_S = 2;
  localparam int ALARM_S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_s = 1'b0, set_min = 1'b0, set_h = 1'b0, set_d = 1'b0;
  logic set_mon = 1'b0, set_y = 1'b0, set_amin = 1'b0, set_ah = 1'b0;
  logic alarm_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [41:0] segment;
  logic alarm;
  logic sec_tick;

  int total = 0;
  int bad = 0;

  rtc_calendar_core #(.CLK_HZ(CLK_HZ), .CYCLE_S(CYCLE_S), .ALARM_S(ALARM_S)) dut (
    .clk(clk), .rst(rst), .set_s(set_s), .set_min(set_min), .set_h(set_h),
    .set_d(set_d), .set_mon(set_mon), .set_y(set_y), .set_amin(set_amin),
    .set_ah(set_ah), .alarm_en(alarm_en), .mode(mode), .segment(segment),
    .alarm(alarm), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_presc, m_sec, m_min, m_hour, m_day, m_mon, m_year, m_amin, m_ahour;
  int m_cnt, m_left;
  bit m_date;
  bit started = 1'b0;
  logic [41:0] m_seg;

  function automatic int dim(int mo, int y);
    if (mo == 2) return (y % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [6:0] dig(int d);
    logic [6:0] on_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    return ~on_pat[d];
  endfunction

  function automatic logic [13:0] pr(int v);
    return {dig(v / 10), dig(v % 10)};
  endfunction

  function automatic logic [41:0] render(int md);
    if (md == 1 || (md == 3 && m_date)) return {pr(m_day), pr(m_mon), pr(m_year)};
    if (md == 2) return {pr(m_ahour), pr(m_amin), 14'h3FFF};
    return {pr(m_hour), pr(m_min), pr(m_sec)};
  endfunction

  always @(posedge clk) begin : model
    int ns, nmi, nh, nd, nmo, ny, nam, nah, d;
    bit tick, c;
    if (rst) begin
      m_presc = 0; m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 0;
      m_amin = 0; m_ahour = 0; m_cnt = 0; m_left = 0; m_date = 1'b0;
      m_seg = render(0);
      started = 1'b1;
    end else if (started) begin
      m_seg = render(int'(mode));
      tick = (m_presc == CLK_HZ - 1);
      ns = set_s ? 0 : (tick ? (m_sec + 1) % 60 : m_sec);
      c = tick && !set_s && m_sec == 59;
      nmi = (set_min || c) ? (m_min + 1) % 60 : m_min;
      c = c && !set_min && m_min == 59;
      nh = (set_h || c) ? (m_hour + 1) % 24 : m_hour;
      c = c && !set_h && m_hour == 23;
      d = dim(m_mon, m_year);
      if (set_d || c) nd = (m_day >= d) ? 1 : m_day + 1;
      else nd = (m_day > d) ? d : m_day;
      c = c && !set_d && m_day >= d;
      nmo = (set_mon || c) ? m_mon % 12 + 1 : m_mon;
      c = c && !set_mon && m_mon == 12;
      ny = (set_y || c) ? (m_year + 1) % 100 : m_year;
      nam = set_amin ? (m_amin + 1) % 60 : m_amin;
      nah = set_ah ? (m_ahour + 1) % 24 : m_ahour;
      if (!alarm_en) m_left = 0;
      else if (tick && nh == nah && nmi == nam && ns == 0) m_left = ALARM_S;
      else if (tick && m_left > 0) m_left = m_left - 1;
      if (mode != 2'd3) begin
        m_cnt = 0; m_date = 1'b0;
      end else if (tick) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == CYCLE_S) begin m_cnt = 0; m_date = !m_date; end
      end
      m_presc = (set_s || tick) ? 0 : m_presc + 1;
      m_sec = ns; m_min = nmi; m_hour = nh; m_day = nd; m_mon = nmo; m_year = ny;
      m_amin = nam; m_ahour = nah;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("segment", segment, m_seg);
      chk("alarm", alarm, (m_left > 0) && alarm_en);
      chk("sec_tick", sec_tick, m_presc == CLK_HZ - 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: set_s = v;
      1: set_min = v;
      2: set_h = v;
      3: set_d = v;
      4: set_mon = v;
      5: set_y = v;
      6: set_amin = v;
      7: set_ah = v;
      default: ;
    endcase
  endtask

  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      drive(which, 1'b1);
      cyc();
      drive(which, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Leaves the bench in the cycle whose closing edge ticks seconds 59 -> 0.
  task automatic wait_last_tick(input string name);
    for (int i = 0; i < 400; i++) begin
      if (m_presc == CLK_HZ - 1 && m_sec == 59) return;
      cyc();
    end
    timeout(name);
  endtask

  task automatic wait_alarm(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (alarm) return;
    end
    timeout(name);
  endtask

  localparam logic [41:0] TIME0    = {6{7'h01}};
  localparam logic [41:0] TIME1    = {7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h4F};
  localparam logic [41:0] DATE0    = {7'h01, 7'h4F, 7'h01, 7'h4F, 7'h01, 7'h01};
  localparam logic [41:0] D290224  = {7'h12, 7'h04, 7'h01, 7'h12, 7'h12, 7'h4C};
  localparam logic [41:0] D010323  = {7'h01, 7'h4F, 7'h01, 7'h06, 7'h12, 7'h06};
  localparam logic [41:0] D300401  = {7'h06, 7'h01, 7'h01, 7'h4C, 7'h01, 7'h4F};
  localparam logic [41:0] T000600  = {7'h01, 7'h01, 7'h01, 7'h20, 7'h01, 7'h01};

  initial begin
    int n;
    logic [41:0] seg_v;
    // reset state
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_segment", segment, TIME0);
    chk("reset_alarm", alarm, 1'b0);
    chk("reset_sec_tick", sec_tick, 1'b0);

    // auto-cycle from reset: 8 cycles of time, then date; mode 2 blanks right pair
    mode = 2'd3;
    do_reset();
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("cycle_time_e4", segment, TIME0);
    repeat (4) @(negedge clk);
    chk("cycle_time_e8", segment, TIME1);
    @(negedge clk);
    chk("cycle_date_e9", segment, DATE0);
    cyc();
    mode = 2'd2;
    cyc();
    @(negedge clk);
    seg_v = segment;
    chk("alarm_view_blank", seg_v[13:0], 14'h3FFF);

    // year rollover 23:59:59 31/12/99 -> 00:00:00 01/01/00
    mode = 2'd0;
    do_reset();
    pulse(5, 99); pulse(4, 11); pulse(3, 30); pulse(2, 23); pulse(1, 59);
    wait_last_tick("rollover_wait");
    cyc();
    chk("roll_model_time", m_hour * 10000 + m_min * 100 + m_sec, 0);
    chk("roll_model_date", m_day * 10000 + m_mon * 100 + m_year, 10100);
    cyc();
    @(negedge clk);
    chk("roll_time_seg", segment, TIME0);
    cyc();
    mode = 2'd1;
    cyc();
    @(negedge clk);
    chk("roll_date_seg", segment, DATE0);

    // leap year 2024 and common year 2023
    for (int yr = 24; yr >= 23; yr--) begin
      do_reset();
      pulse(5, yr); pulse(4, 1); pulse(3, 27); pulse(2, 23); pulse(1, 59);
      wait_last_tick("leap_wait");
      cyc();
      chk("leap_model", m_day * 100 + m_mon, (yr == 24) ? 2902 : 103);
      cyc();
      @(negedge clk);
      chk("leap_seg", segment, (yr == 24) ? D290224 : D010323);
    end

    // clamp 31/03/01 + set_mon -> 30/04/01
    do_reset();
    pulse(5, 1); pulse(4, 2); pulse(3, 30);
    pulse(4, 1);
    cyc();
    chk("clamp_model", m_day * 100 + m_mon, 3004);
    cyc();
    @(negedge clk);
    chk("clamp_seg", segment, D300401);

    // set_min coincident with the seconds carry: +1 only
    mode = 2'd0;
    do_reset();
    pulse(1, 5);
    wait_last_tick("prio_wait");
    set_min = 1'b1;
    cyc();
    set_min = 1'b0;
    chk("prio_model", m_min * 100 + m_sec, 600);
    cyc();
    @(negedge clk);
    chk("prio_seg", segment, T000600);

    // alarm at 00:01 held 12 cycles; second alarm dropped by alarm_en
    do_reset();
    alarm_en = 1'b1;
    pulse(6, 1);
    wait_alarm("alarm_wait");
    chk("alarm_rise_model", m_min * 100 + m_sec, 100);
    n = 0;
    while (alarm && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("alarm_length", n, 12);
    cyc();
    pulse(6, 1);
    wait_alarm("alarm2_wait");
    repeat (5) cyc();
    alarm_en = 1'b0;
    cyc();
    @(negedge clk);
    chk("alarm_en_off", alarm, 1'b0);
    cyc();
    alarm_en = 1'b1;

    // randomized operation against the model
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 31);
      if (n < 8) drive(n, 1'b1);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) alarm_en = !alarm_en;
      rst = ($urandom_range(0, 1499) == 0);
      cyc();
      for (int k = 0; k < 8; k++) drive(k, 1'b0);
      rst = 1'b0;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_calendar_core.md
RTC_CALENDAR_CORE -- requirements
Module: rtc_calendar_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clock cycles per second (>=2).
REQ-002 SHALL have parameter CYCLE_S, default 5, seconds per view in auto-cycle mode (1..59).
REQ-003 SHALL have parameter ALARM_S, default 30, seconds the alarm output stays high (1..59).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-006 SHALL have ports set_s, set_min, set_h, set_d, set_mon, set_y  input  1 each  single-cycle adjust pulses.
REQ-007 SHALL have ports set_amin, set_ah  input  1 each  alarm minute/hour adjust pulses.
REQ-008 SHALL have port alarm_en  input  1  alarm enable level.
REQ-009 SHALL have port mode  input  2  view: 0 time, 1 date, 2 alarm, 3 auto-cycle.
REQ-010 SHALL have port segment  output  42  six 7-seg digits, active-low.
REQ-011 SHALL have port alarm  output  1  alarm indication.
REQ-012 SHALL have port sec_tick  output  1  one-cycle pulse each second.

Function
REQ-013 SHALL count a prescaler 0..CLK_HZ-1; sec_tick high in the cycle the prescaler wraps.
REQ-014 SHALL count seconds 0..59, minutes 0..59, hours 0..23, day 1..days_in_month, month 1..12, year 0..99 (year 2000+y), each carrying to the next field on wrap in the same cycle as sec_tick.
REQ-015 SHALL use days_in_month 31 (1,3,5,7,8,10,12), 30 (4,6,9,11), February 29 when year%4==0 else 28.
REQ-016 SHALL wrap year 99 -> 0 on carry out of 31 Dec, with no further carry.
REQ-017 SHALL, on set_s, clear seconds and prescaler to 0 without carry.
REQ-018 SHALL, on any other set_* pulse, increment that field by one wrapping within its own range (min 59->0, h 23->0, d last->1, mon 12->1, y 99->0, amin 59->0, ah 23->0), with no carry to other fields.
REQ-019 SHALL give a set pulse priority over a coincident carry into the same field; that carry is discarded, lower fields still update.
REQ-020 SHALL clamp day to days_in_month in the cycle after a month or year change leaves day out of range (e.g. 31 Mar, set_mon -> 30 Apr).
REQ-021 SHALL assert alarm on the sec_tick at which, after update, hours==alarm hour, minutes==alarm minute, seconds==0 and alarm_en==1; hold it ALARM_S seconds, then deassert.
REQ-022 SHALL deassert alarm in the same cycle alarm_en goes low.
REQ-023 SHALL display, per view, left/middle/right digit pairs: time hh/mm/ss; date dd/mm/yy; alarm hh/mm/blank.
REQ-024 SHALL, in mode 3, alternate time and date views every CYCLE_S sec_ticks, starting with time; the cycle counter restarts at time view whenever mode changes to 3.
REQ-025 SHALL map segment[41:28] left, [27:14] middle, [13:0] right pair; within a pair [13:7] tens, [6:0] units; within a digit bit6..bit0 = a..g, 0 = lit.
REQ-026 SHALL register segment, so it reflects counter state with exactly one cycle latency.
REQ-027 SHALL drive blank digits as all ones.

Reset
REQ-028 SHALL, while rst is high at a clock edge, load 00:00:00, day 1, month 1, year 0, alarm 00:00, prescaler 0, cycle counter 0; alarm=0, sec_tick=0, segment = time view of 00:00:00 on the following edge.
REQ-029 SHALL give rst priority over all set pulses and ticks, including mid-alarm and mid-cycle.

Verification (CLK_HZ=4, CYCLE_S=2, ALARM_S=3)
REQ-030 SHALL verify rollover: set 23:59:59 31/12/99, one sec_tick -> 00:00:00 01/01/00.
REQ-031 SHALL verify leap: 28/02/24 23:59:59 + tick -> 29/02/24; 28/02/23 + same -> 01/03/23.
REQ-032 SHALL verify clamp: 31/03/01, set_mon pulse -> 30/04/01 within two cycles.
REQ-033 SHALL verify alarm: alarm 00:01, alarm_en=1, run from 00:00:00 -> alarm high at 00:01:00 for 12 cycles; alarm_en low mid-way -> alarm low next edge.
REQ-034 SHALL verify set/carry priority: set_min coincident with seconds 59->0 -> minutes +1 only (not +2), seconds 0.
REQ-035 SHALL verify display: mode 3 from reset -> segment shows time for 8 cycles, then date 01/01/00, alternating; mode 2 -> right pair 14'h3FFF.
